jtdsp16_boot: RTL



---
 rtl/jtdsp16_boot_pkg.sv | 16 +
 rtl/jtdsp16_boot_fetch.sv | 41 ++++
 rtl/jtdsp16_boot.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jtdsp16_boot_pkg.sv
// Shared types and constants for the jtdsp16 boot sequencer.
package jtdsp16_boot_pkg;

  localparam int PROG_AW = 13;
  localparam int MAX_IMG = 8192;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_HOLD = 3'd4,
    S_RUN  = 3'd5
  } state_t;

endpackage

// File: rtl/jtdsp16_boot_fetch.sv
// Byte fetch handshake: registers address/request, returns the byte with a
// one-cycle valid strobe as soon as the memory acknowledges.
module jtdsp16_boot_fetch #(
  parameter int          AW   = 22,
  parameter int unsigned BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          abort,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_cs,
  input  logic          mem_ok,
  input  logic [7:0]    mem_data
);

  // mem_cs only rises the cycle after req, so mem_ok is never sampled
  // against the address of the previous byte.
  assign valid = mem_cs & mem_ok;
  assign data  = mem_data;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= AW'(BASE);
      mem_cs   <= 1'b0;
    end else if (abort) begin
      mem_cs   <= 1'b0;
    end else if (req) begin
      mem_addr <= addr;
      mem_cs   <= 1'b1;
    end else if (valid) begin
      mem_cs   <= 1'b0;
    end
  end

endmodule

// File: rtl/jtdsp16_boot.sv
// Boot sequencer: copies the program ROM image into jtdsp16, then releases
// its reset. Optional macro JTDSP16_BOOT_REBOOT_EN: reload on DSP fault.
module jtdsp16_boot
  import jtdsp16_boot_pkg::*;
#(
  parameter int          AW      = 22,
  parameter int unsigned BASE    = 0,
  parameter int          IMG_LEN = 8192,
  parameter int          HOLD    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_cs,
  input  logic               mem_ok,
  input  logic [7:0]         mem_data,
  output logic [PROG_AW-1:0] prog_addr,
  output logic [7:0]         prog_data,
  output logic               prog_we,
  output logic               dsp_rst,
  output logic               busy,
  output logic               done,
  input  logic               fault
`ifdef JTDSP16_BOOT_REBOOT_EN
  ,
  output logic [3:0]         reboots
`endif
);

  localparam logic [PROG_AW-1:0] LAST      = PROG_AW'(IMG_LEN - 1);
  localparam logic [7:0]         HOLD_LAST = 8'(HOLD - 1);

  state_t             state, state_nx;
  logic [PROG_AW-1:0] cnt, cnt_nx;
  logic [7:0]         hold_cnt, hold_nx;
  logic               restart;
  logic [AW-1:0]      fetch_addr;
  logic [7:0]         fetch_data;
  logic               fetch_valid;

`ifdef JTDSP16_BOOT_REBOOT_EN
  logic auto_start;
  assign auto_start = (state == S_RUN) && fault;
  assign restart    = start | auto_start;

  always_ff @(posedge clk) begin
    if (rst)
      reboots <= 4'd0;
    else if (auto_start && reboots != 4'hF)
      reboots <= reboots + 4'd1;
  end
`else
  logic unused_fault;
  assign unused_fault = fault;
  assign restart      = start;
`endif

  // Address arithmetic wraps modulo 2^AW by construction.
  assign fetch_addr = AW'(BASE) + AW'(cnt);

  jtdsp16_boot_fetch #(
    .AW   (AW),
    .BASE (BASE)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .req      ((state == S_ADDR) && !restart),
    .abort    (restart),
    .addr     (fetch_addr),
    .data     (fetch_data),
    .valid    (fetch_valid),
    .mem_addr (mem_addr),
    .mem_cs   (mem_cs),
    .mem_ok   (mem_ok),
    .mem_data (mem_data)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold_nx  = hold_cnt;
    unique case (state)
      S_IDLE: ;
      S_ADDR: state_nx = S_WAIT;
      S_WAIT: if (fetch_valid) state_nx = S_WR;
      S_WR: begin
        if (cnt == LAST) begin
          state_nx = S_HOLD;
          hold_nx  = 8'd0;
        end else begin
          state_nx = S_ADDR;
          cnt_nx   = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = S_RUN;
        else                       hold_nx  = hold_cnt + 8'd1;
      end
      S_RUN:  ;
      default: state_nx = S_IDLE;
    endcase
    // A start pulse overrides whatever the sequence was doing.
    if (restart) begin
      state_nx = S_ADDR;
      cnt_nx   = '0;
    end
  end

  // Outputs are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold_cnt  <= 8'd0;
      prog_addr <= '0;
      prog_data <= 8'd0;
      prog_we   <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      hold_cnt <= hold_nx;
      prog_we  <= (state_nx == S_WR);
      dsp_rst  <= (state_nx != S_RUN);
      busy     <= (state_nx != S_IDLE) && (state_nx != S_RUN);
      done     <= (state_nx == S_RUN);
      if (state == S_WAIT && fetch_valid && !restart) begin
        prog_addr <= cnt;
        prog_data <= fetch_data;
      end
    end
  end

endmodule
